// File: rtl/fft_dit_stage_controller.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT.
// One butterfly issue per two cycles, write-back delayed by WB_DELAY.
module fft_dit_stage_controller #(
    parameter int N        = 8,
    parameter int LOG2N    = 3,
    parameter int WB_DELAY = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr0,
    output logic [LOG2N-1:0] rd_addr1,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr0,
    output logic [LOG2N-1:0] wr_addr1,
    output logic [LOG2N-1:0] stage
);

    localparam int BW = LOG2N - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic              phase;
    logic [BW-1:0]     b;
    logic [LOG2N-1:0]  stg;
    logic [LOG2N-1:0]  bx, span, j, g, a0, a1;
    logic [BW-1:0]     tw_c;
    logic [LOG2N-1:0]  a0_q, a1_q;
    logic [BW-1:0]     tw_q;
    logic              issue, last_b, last_wr, stg_last;
    logic [WB_DELAY-1:0] dl_v;
    logic [LOG2N-1:0]  dl_a0 [WB_DELAY];
    logic [LOG2N-1:0]  dl_a1 [WB_DELAY];

    always_comb begin
        bx   = {1'b0, b};
        span = LOG2N'(1) << stg;
        j    = bx & (span - LOG2N'(1));
        g    = bx >> stg;
        a0   = (g << (stg + LOG2N'(1))) | j;
        a1   = a0 + span;
        tw_c = BW'(j << (LOG2N'(LOG2N - 1) - stg));
    end

    assign issue    = (state == RUN) && !phase;
    assign last_b   = (b == BW'(N / 2 - 1));
    assign stg_last = (stg == LOG2N'(LOG2N - 1));
    // Final write of the stage is on the bus and nothing else is in flight.
    assign last_wr  = dl_v[WB_DELAY-1] && (dl_v[WB_DELAY-2:0] == '0);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = RUN;
            RUN:   if (issue && last_b) state_n = DRAIN;
            DRAIN: if (last_wr) state_n = stg_last ? DONE : RUN;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= 1'b0;
            b     <= '0;
            stg   <= '0;
            a0_q  <= '0;
            a1_q  <= '0;
            tw_q  <= '0;
            dl_v  <= '0;
            for (int i = 0; i < WB_DELAY; i++) begin
                dl_a0[i] <= '0;
                dl_a1[i] <= '0;
            end
        end else begin
            state <= state_n;
            phase <= ~phase;
            if (state == IDLE && start) begin
                b   <= '0;
                stg <= '0;
            end
            if (issue) begin
                b    <= last_b ? '0 : b + 1'b1;
                a0_q <= a0;
                a1_q <= a1;
                tw_q <= tw_c;
            end
            if (state == DRAIN && last_wr && !stg_last)
                stg <= stg + 1'b1;
            if (state == DONE)
                stg <= '0;
            dl_v     <= {dl_v[WB_DELAY-2:0], issue};
            dl_a0[0] <= a0;
            dl_a1[0] <= a1;
            for (int i = 1; i < WB_DELAY; i++) begin
                dl_a0[i] <= dl_a0[i-1];
                dl_a1[i] <= dl_a1[i-1];
            end
        end
    end

    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign rd_en    = issue;
    assign rd_addr0 = issue ? a0 : a0_q;
    assign rd_addr1 = issue ? a1 : a1_q;
    assign tw_addr  = issue ? tw_c : tw_q;
    assign wr_en    = dl_v[WB_DELAY-1];
    assign wr_addr0 = dl_a0[WB_DELAY-1];
    assign wr_addr1 = dl_a1[WB_DELAY-1];
    assign stage    = stg;

endmodule
